// File: rtl/vga_scan_out.sv
// VGA scan-out timing generator: pixel divider, h/v scan counters, one-pixel
// registered colour and sync outputs aligned to each other.
module vga_scan_out #(
    parameter int unsigned PIXLW    = 12,
    parameter int unsigned INTW     = 16,
    parameter int unsigned PIX_DIV  = 4,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [INTW-1:0]  x,
    output logic [INTW-1:0]  y,
    output logic             active,
    input  logic [PIXLW-1:0] render,
    output logic [3:0]       vga_r,
    output logic [3:0]       vga_g,
    output logic [3:0]       vga_b,
    output logic             vga_hs,
    output logic             vga_vs,
    output logic             pix_tick,
    output logic             frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int unsigned VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
    localparam int unsigned DIVW    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [HW-1:0]   H_MAX   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0]   V_MAX   = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0]   H_ACT   = HW'(H_ACTIVE);
    localparam logic [VW-1:0]   V_ACT   = VW'(V_ACTIVE);
    localparam logic [HW-1:0]   HS_LO   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0]   HS_HI   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0]   VS_LO   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0]   VS_HI   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [DIVW-1:0] DIV_MAX = DIVW'(PIX_DIV - 1);

    logic            r_run;
    logic [DIVW-1:0] r_div;
    logic            r_tick;
    logic            r_frame;
    logic [HW-1:0]   r_hcnt;
    logic [VW-1:0]   r_vcnt;
    logic [11:0]     r_rgb;
    logic            r_hs;
    logic            r_vs;

    logic [DIVW-1:0] w_div_nxt;
    logic            w_tick_nxt;
    logic [HW-1:0]   w_h_nxt;
    logic [VW-1:0]   w_v_nxt;
    logic            w_active;
    logic            w_in_hs;
    logic            w_in_vs;

    // Divider advance; it idles at 0 for the first clock after reset release
    // so the first tick lands PIX_DIV clocks after release.
    always_comb begin
        w_div_nxt = '0;
        if (r_run) begin
            w_div_nxt = (r_div == DIV_MAX) ? '0 : r_div + DIVW'(1);
        end
        w_tick_nxt = (w_div_nxt == DIV_MAX);
    end

    // Scan counter advance, applied only on tick clocks.
    always_comb begin
        w_h_nxt = r_hcnt;
        w_v_nxt = r_vcnt;
        if (r_tick) begin
            if (r_hcnt == H_MAX) begin
                w_h_nxt = '0;
                w_v_nxt = (r_vcnt == V_MAX) ? '0 : r_vcnt + VW'(1);
            end else begin
                w_h_nxt = r_hcnt + HW'(1);
            end
        end
    end

    // Visibility and sync windows of the current (pre-tick) counters.
    always_comb begin
        w_active = (r_hcnt < H_ACT) && (r_vcnt < V_ACT);
        w_in_hs  = (r_hcnt >= HS_LO) && (r_hcnt <= HS_HI);
        w_in_vs  = (r_vcnt >= VS_LO) && (r_vcnt <= VS_HI);
    end

    // Timing state and pixel-delayed output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_run   <= 1'b0;
            r_div   <= '0;
            r_tick  <= 1'b0;
            r_frame <= 1'b0;
            r_hcnt  <= '0;
            r_vcnt  <= '0;
            r_rgb   <= '0;
            r_hs    <= 1'b1;
            r_vs    <= 1'b1;
        end else begin
            r_run   <= 1'b1;
            r_div   <= w_div_nxt;
            r_tick  <= w_tick_nxt;
            r_frame <= w_tick_nxt && (w_h_nxt == H_MAX) && (w_v_nxt == V_MAX);
            r_hcnt  <= w_h_nxt;
            r_vcnt  <= w_v_nxt;
            if (r_tick) begin
                r_rgb <= w_active ? render[11:0] : 12'h000;
                r_hs  <= !w_in_hs;
                r_vs  <= !w_in_vs;
            end
        end
    end

    assign x           = INTW'(r_hcnt);
    assign y           = INTW'(r_vcnt);
    assign active      = w_active;
    assign vga_r       = r_rgb[11:8];
    assign vga_g       = r_rgb[7:4];
    assign vga_b       = r_rgb[3:0];
    assign vga_hs      = r_hs;
    assign vga_vs      = r_vs;
    assign pix_tick    = r_tick;
    assign frame_start = r_frame;

endmodule

// File: tb/tb_vga_scan_out.sv
// Bench for vga_scan_out: default-timing instance A and a tiny PIX_DIV=1
// instance B, both checked every clock against an index-arithmetic model.
module tb_vga_scan_out;

    typedef struct {
        int unsigned pd;
        int unsigned ha, hf, hs, hb;
        int unsigned va, vf, vs, vb;
    } geom_t;

    typedef struct {
        int unsigned k;
        int unsigned x;
        int unsigned y;
        logic        act;
        logic        tick;
        logic        hs;
        logic [11:0] rgb;
    } vec_t;

    localparam geom_t GA = '{4, 640, 16, 96, 48, 480, 10, 2, 33};
    localparam geom_t GB = '{1, 8, 1, 2, 1, 4, 1, 1, 1};

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] render_a, render_b;
    logic [15:0] x_a, y_a, x_b, y_b;
    logic        act_a, act_b;
    logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b;
    logic        hs_a, vs_a, hs_b, vs_b, tick_a, tick_b, fs_a, fs_b;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned ka = 0, kb = 0;
    bit          mvalid = 1'b0;
    bit          rand_mode = 1'b0;
    logic [11:0] ea_rgb, eb_rgb;
    logic        ea_hs, ea_vs, eb_hs, eb_vs;
    int unsigned cyc = 0;
    int unsigned hs_low_a = 0;
    int unsigned fs_cnt_b = 0;
    int unsigned last_fs_b = 0;
    bit          have_fs_b = 1'b0;

    always #5 clk = ~clk;

    vga_scan_out u_a (
        .clk(clk), .rst_n(rst_n), .x(x_a), .y(y_a), .active(act_a),
        .render(render_a), .vga_r(r_a), .vga_g(g_a), .vga_b(b_a),
        .vga_hs(hs_a), .vga_vs(vs_a), .pix_tick(tick_a), .frame_start(fs_a)
    );

    vga_scan_out #(
        .PIX_DIV(1), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .x(x_b), .y(y_b), .active(act_b),
        .render(render_b), .vga_r(r_b), .vga_g(g_b), .vga_b(b_b),
        .vga_hs(hs_b), .vga_vs(vs_b), .pix_tick(tick_b), .frame_start(fs_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic int unsigned pix_index(input geom_t g, input int unsigned k);
        return (k == 0) ? 0 : (k - 1) / g.pd;
    endfunction

    // Model: k released edges so far; pixel n is on the counters, outputs show pixel n-1.
    task automatic model_step(input geom_t g, input int unsigned k, input logic [11:0] rnd,
                              inout logic [11:0] rgb, inout logic hs, inout logic vs);
        int unsigned ht, vt, n, h, v;
        ht = g.ha + g.hf + g.hs + g.hb;
        vt = g.va + g.vf + g.vs + g.vb;
        if (k >= 1 && (k % g.pd) == 0) begin
            n   = pix_index(g, k);
            h   = n % ht;
            v   = (n / ht) % vt;
            rgb = (h < g.ha && v < g.va) ? rnd : 12'h000;
            hs  = !(h >= g.ha + g.hf && h < g.ha + g.hf + g.hs);
            vs  = !(v >= g.va + g.vf && v < g.va + g.vf + g.vs);
        end
    endtask

    task automatic check_inst(input string p, input geom_t g, input int unsigned k,
                              input logic [15:0] x, input logic [15:0] y, input logic act,
                              input logic tick, input logic fs, input logic [11:0] rgb,
                              input logic hs, input logic vs, input logic [11:0] ergb,
                              input logic ehs, input logic evs);
        int unsigned ht, vt, n, h, v;
        logic etick;
        ht    = g.ha + g.hf + g.hs + g.hb;
        vt    = g.va + g.vf + g.vs + g.vb;
        n     = pix_index(g, k);
        h     = n % ht;
        v     = (n / ht) % vt;
        etick = (k >= 1) && ((k % g.pd) == 0);
        chk({p, ".x"}, 32'(x), h);
        chk({p, ".y"}, 32'(y), v);
        chk({p, ".active"}, 32'(act), 32'(h < g.ha && v < g.va));
        chk({p, ".pix_tick"}, 32'(tick), 32'(etick));
        chk({p, ".frame_start"}, 32'(fs), 32'(etick && h == ht - 1 && v == vt - 1));
        chk({p, ".rgb"}, 32'(rgb), 32'(ergb));
        chk({p, ".hs"}, 32'(hs), 32'(ehs));
        chk({p, ".vs"}, 32'(vs), 32'(evs));
    endtask

    // Reference model update at every active edge.
    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                ka = 0; kb = 0;
                ea_rgb = 12'h000; ea_hs = 1'b1; ea_vs = 1'b1;
                eb_rgb = 12'h000; eb_hs = 1'b1; eb_vs = 1'b1;
                mvalid = 1'b1;
            end else if (mvalid) begin
                model_step(GA, ka, render_a, ea_rgb, ea_hs, ea_vs);
                model_step(GB, kb, render_b, eb_rgb, eb_hs, eb_vs);
                ka++;
                kb++;
            end
        end
    end

    // Per-clock comparison on the falling edge, plus hsync and frame bookkeeping.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (mvalid) begin
                check_inst("A", GA, ka, x_a, y_a, act_a, tick_a, fs_a, {r_a, g_a, b_a},
                           hs_a, vs_a, ea_rgb, ea_hs, ea_vs);
                check_inst("B", GB, kb, x_b, y_b, act_b, tick_b, fs_b, {r_b, g_b, b_b},
                           hs_b, vs_b, eb_rgb, eb_hs, eb_vs);
                if (ka >= 1 && ka <= 3205 && hs_a == 1'b0) hs_low_a++;
                if (kb == 0) have_fs_b = 1'b0;
                if (fs_b === 1'b1) begin
                    fs_cnt_b++;
                    if (have_fs_b) chk("B.frame_period", cyc - last_fs_b, 84);
                    last_fs_b = cyc;
                    have_fs_b = 1'b1;
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        render_b = 12'($urandom);
        if (rand_mode) render_a = 12'($urandom);
    endtask

    task automatic wait_k(input int unsigned target);
        int unsigned guard = 0;
        while (ka != target && guard < 20000) begin
            step();
            guard++;
        end
        chk("wait_k", ka, target);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[14];
        vecs[0]  = '{0,    0,   0, 1'b1, 1'b0, 1'b1, 12'h000};
        vecs[1]  = '{1,    0,   0, 1'b1, 1'b0, 1'b1, 12'h000};
        vecs[2]  = '{4,    0,   0, 1'b1, 1'b1, 1'b1, 12'h000};
        vecs[3]  = '{5,    1,   0, 1'b1, 1'b0, 1'b1, 12'hA5C};
        vecs[4]  = '{8,    1,   0, 1'b1, 1'b1, 1'b1, 12'hA5C};
        vecs[5]  = '{2561, 640, 0, 1'b0, 1'b0, 1'b1, 12'hA5C};
        vecs[6]  = '{2565, 641, 0, 1'b0, 1'b0, 1'b1, 12'h000};
        vecs[7]  = '{2628, 656, 0, 1'b0, 1'b1, 1'b1, 12'h000};
        vecs[8]  = '{2629, 657, 0, 1'b0, 1'b0, 1'b0, 12'h000};
        vecs[9]  = '{3012, 752, 0, 1'b0, 1'b1, 1'b0, 12'h000};
        vecs[10] = '{3013, 753, 0, 1'b0, 1'b0, 1'b1, 12'h000};
        vecs[11] = '{3197, 799, 0, 1'b0, 1'b0, 1'b1, 12'h000};
        vecs[12] = '{3201, 0,   1, 1'b1, 1'b0, 1'b1, 12'h000};
        vecs[13] = '{3205, 1,   1, 1'b1, 1'b0, 1'b1, 12'hA5C};

        rst_n    = 1'b0;
        render_a = 12'hA5C;
        render_b = 12'h000;
        repeat (3) step();

        // Fixed-colour table walk through line 0 of instance A.
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].k != 0) wait_k(vecs[i].k);
            chk($sformatf("vec%0d.x", i), 32'(x_a), vecs[i].x);
            chk($sformatf("vec%0d.y", i), 32'(y_a), vecs[i].y);
            chk($sformatf("vec%0d.active", i), 32'(act_a), 32'(vecs[i].act));
            chk($sformatf("vec%0d.pix_tick", i), 32'(tick_a), 32'(vecs[i].tick));
            chk($sformatf("vec%0d.hs", i), 32'(hs_a), 32'(vecs[i].hs));
            chk($sformatf("vec%0d.vs", i), 32'(vs_a), 32'(1'b1));
            chk($sformatf("vec%0d.rgb", i), 32'({r_a, g_a, b_a}), 32'(vecs[i].rgb));
            if (i == 0) rst_n = 1'b1;
        end
        chk("A.hs_low_clks_line0", hs_low_a, 96 * 4);

        // Random colours, then reset in the middle of a pixel at (300,1).
        rand_mode = 1'b1;
        wait_k(4 * 1100 + 3);
        chk("pre_reset.x", 32'(x_a), 300);
        chk("pre_reset.y", 32'(y_a), 1);
        rst_n = 1'b0;
        step();
        chk("reset.x", 32'(x_a), 0);
        chk("reset.y", 32'(y_a), 0);
        chk("reset.rgb", 32'({r_a, g_a, b_a}), 0);
        chk("reset.hs", 32'(hs_a), 1);
        chk("reset.vs", 32'(vs_a), 1);
        chk("reset.pix_tick", 32'(tick_a), 0);
        chk("reset.frame_start", 32'(fs_a), 0);
        chk("reset.B_pix_tick", 32'(tick_b), 0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        chk("restart.x", 32'(x_a), 0);
        chk("restart.y", 32'(y_a), 0);
        chk("restart.pix_tick", 32'(tick_a), 0);
        chk("restart.B_pix_tick", 32'(tick_b), 1);

        repeat (6000) step();
        chk("B.frame_count_min", 32'(fs_cnt_b > 100), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
